// File: rtl/shift_tx_ctrl_if.sv
// Upstream word handshake into shift_tx_ctrl: valid/ready plus word and bit order.
interface shift_tx_ctrl_if #(
   parameter int WIDTH = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_msb_first;

   modport master (output in_valid, output in_data, output in_msb_first, input in_ready);
   modport slave  (input in_valid, input in_data, input in_msb_first, output in_ready);
endinterface

// File: rtl/shift_tx_ctrl.sv
// Loads a word into the external universal shift register and serializes it one bit per clock.
// Optional SHIFT_TX_ROTATE_EN recirculates the outgoing bit so the register ends holding the original word.
module shift_tx_ctrl #(
   parameter int   WIDTH    = 8,
   parameter int   CNT_W    = 4,
   parameter logic FILL_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   shift_tx_ctrl_if.slave   up,
   output logic             sr_s0,
   output logic             sr_s1,
   output logic [WIDTH-1:0] sr_par_in,
   output logic             sr_ser_in_sr,
   output logic             sr_ser_in_sl,
   input  logic [WIDTH-1:0] sr_par_out,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_par_in;
   logic             r_dir;
   logic             w_accept;
   logic             w_last;
   logic             w_unused;

   assign up.in_ready = (r_state == S_IDLE);
   assign w_accept    = up.in_valid & up.in_ready;
   assign w_last      = (r_cnt == LAST);
   assign sr_par_in   = r_par_in;
   assign busy        = (r_state != S_IDLE);
   assign ser_out     = r_dir ? sr_par_out[WIDTH-1] : sr_par_out[0];
   assign w_unused    = ^sr_par_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_par_in <= '0;
         r_dir    <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_par_in <= up.in_data;
               r_dir    <= up.in_msb_first;
            end
            S_LOAD:  r_cnt <= '0;
            // clear on the last bit so the counter never passes WIDTH-1
            S_SHIFT: r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next    = r_state;
      sr_s1     = 1'b0;
      sr_s0     = 1'b0;
      ser_valid = 1'b0;
      done      = 1'b0;
      case (r_state)
         S_IDLE: if (w_accept) w_next = S_LOAD;
         S_LOAD: begin
            sr_s1  = 1'b1;
            sr_s0  = 1'b1;
            w_next = S_SHIFT;
         end
         S_SHIFT: begin
            sr_s1     = r_dir;
            sr_s0     = ~r_dir;
            ser_valid = 1'b1;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

`ifdef SHIFT_TX_ROTATE_EN
   // feed the departing bit back into the vacated end of the active direction
   assign sr_ser_in_sr = (r_state == S_SHIFT && !r_dir) ? sr_par_out[0]       : FILL_BIT;
   assign sr_ser_in_sl = (r_state == S_SHIFT &&  r_dir) ? sr_par_out[WIDTH-1] : FILL_BIT;
`else
   assign sr_ser_in_sr = FILL_BIT;
   assign sr_ser_in_sl = FILL_BIT;
`endif
endmodule

// File: doc/shift_tx_ctrl.md
Name: shift_tx_ctrl

Overview:
- Sequencer that sits directly upstream of the WIDTH-bit universal shift register built from the 2-bit slices.
- Accepts a parallel word over a valid/ready handshake. Drives the register's mode selects, parallel and serial inputs to load the word, then shifts it out one bit per clock.
- Observes the register's parallel output to present the outgoing serial bit with a qualifier and an end-of-word pulse.

Parameters:
- WIDTH, 8, word width; must equal the width of the driven shift-register chain (even, ≥2).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.
- FILL_BIT, 1'b0, value shifted into the vacated end when rotation is not compiled in.

Ports:
- clk  input  1  rising-edge clock shared with the shift register.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream word available.
- in_ready  output  1  controller can accept a word.
- in_data  input  WIDTH  word to serialize.
- in_msb_first  input  1  direction: 1 = MSB first (shift left), 0 = LSB first (shift right); sampled with in_data.
- sr_s0  output  1  shift register mode select bit 0.
- sr_s1  output  1  shift register mode select bit 1.
- sr_par_in  output  WIDTH  parallel load data to the shift register.
- sr_ser_in_sr  output  1  serial input entering the MSB on shift right.
- sr_ser_in_sl  output  1  serial input entering the LSB on shift left.
- sr_par_out  input  WIDTH  shift register parallel output (feedback).
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out is a valid data bit this cycle.
- busy  output  1  word in progress (any state other than IDLE).
- done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Mode encoding {sr_s1,sr_s0}:
  - 00 = hold.
  - 01 = shift right: ser_in_sr enters the MSB; the LSB falls out.
  - 10 = shift left: ser_in_sl enters the LSB; the MSB falls out.
  - 11 = parallel load.
- All outputs are registered or decoded from registered state. ser_out is the exception: it is combinational from sr_par_out.
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, sr_par_in=0, direction flag=0.
  - {sr_s1,sr_s0}=00, sr_ser_in_sr=sr_ser_in_sl=FILL_BIT.
  - ser_valid=0, done=0, busy=0.
  - in_ready=1 once rst_n is released.
  - Reset does not clear the shift register itself.
- FSM IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
- IDLE:
  - in_ready=1, mode=00.
  - On in_valid & in_ready at edge k: capture in_data into sr_par_in and in_msb_first into the direction flag; go to LOAD.
- LOAD:
  - One cycle (k+1), mode=11; the register captures sr_par_in at the end of this cycle. counter=0.
- SHIFT:
  - WIDTH cycles (k+2 .. k+WIDTH+1).
  - Mode=10 if the direction flag is set, else 01.
  - ser_valid=1. ser_out = sr_par_out[WIDTH-1] (MSB first) or sr_par_out[0] (LSB first).
  - Counter increments each cycle. When counter==WIDTH-1, go to DONE.
- DONE:
  - One cycle (k+WIDTH+2), done=1, mode=00, ser_valid=0; go to IDLE.
- Throughput: WIDTH+3 cycles per word; in_ready is high only in IDLE.
- in_valid and in_data changes outside IDLE are ignored; no word is lost because ready is low.
- in_ready=1 while in_valid=0: the controller stays in IDLE, mode 00.
- rst_n asserted mid-word: the controller returns immediately to IDLE with mode 00. The partial word is abandoned and done does not pulse.
- Counter never exceeds WIDTH-1; no wrap occurs in normal operation.

Optional Feature:
- Macro SHIFT_TX_ROTATE_EN.
- Defined: the fill input for the active direction is driven with the bit leaving the register that cycle, so the register rotates.
  - sr_ser_in_sr = sr_par_out[0] during shift right.
  - sr_ser_in_sl = sr_par_out[WIDTH-1] during shift left.
  - After DONE, sr_par_out equals the original word.
- Undefined: both serial inputs are constant FILL_BIT; after DONE, sr_par_out is all FILL_BIT.

Test Plan:
- Reset held low mid-SHIFT (bit 3 of 8) -> mode=00, ser_valid=0, busy=0 immediately; no done pulse. After release, in_ready=1.
- in_data=8'hB4, in_msb_first=0, handshake at edge k -> mode=11 at k+1. ser_out over k+2..k+9 = 0,0,1,0,1,1,0,1 with ser_valid=1. done=1 at k+10.
- in_data=8'hB4, in_msb_first=1 -> mode=10 during SHIFT; ser_out = 1,0,1,1,0,1,0,0; done after 8 bits.
- in_valid held high with a new word 8'h3C during SHIFT -> in_ready=0 and the word is not taken. It is accepted in IDLE after done; back-to-back period is 11 cycles.
- SHIFT_TX_ROTATE_EN defined, word 8'h96 LSB first -> after done, sr_par_out=8'h96. Undefined with FILL_BIT=0 -> sr_par_out=8'h00.
- in_valid=0 for 20 cycles -> mode stays 00, sr_par_out unchanged, busy=0, done never asserts.
